stack_sequencer: RTL and testbench

- Controller that sequences the 8-bit data stack (DS) and return stack (RS) memories for FORTH stack primitives.
- Caches the data-stack top in its own TOS register.
- Issues 2-bit mode commands (00 clear, 01 push, 10 pop, 11 idle) to each stack, and drives or samples each stack's bidirectional bus.
- Tracks the depth of both stacks and rejects overflow and underflow.

---
 rtl/stack_sequencer.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: micro-sequences FORTH stack primitives over two external
// stack memories (data stack DS, return stack RS). The DS top lives in a local
// TOS register; memories are driven with 2-bit mode commands and a shared
// bidirectional data bus per stack.
module stack_sequencer #(
    parameter int WIDTH     = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] lit_in,
    output logic [WIDTH-1:0] tos,
    output logic [8:0]       ds_depth,
    output logic [8:0]       rs_depth,
    output logic [1:0]       ds_mode,
    inout  wire  [WIDTH-1:0] ds_bus,
    output logic [1:0]       rs_mode,
    inout  wire  [WIDTH-1:0] rs_bus,
    output logic             error,
    output logic [1:0]       err_code
);

    localparam logic [8:0] DS_CAP = 9'(MEM_DEPTH + 1);
    localparam logic [8:0] RS_CAP = 9'(MEM_DEPTH);

    localparam logic [1:0] M_CLR  = 2'b00;
    localparam logic [1:0] M_PUSH = 2'b01;
    localparam logic [1:0] M_POP  = 2'b10;
    localparam logic [1:0] M_IDLE = 2'b11;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_LIT = 4'd1, OP_DROP = 4'd2, OP_DUP = 4'd3,
        OP_SWAP = 4'd4, OP_OVER = 4'd5, OP_TO_R = 4'd6, OP_R_FROM = 4'd7,
        OP_R_FETCH = 4'd8, OP_CLEAR = 4'd9
    } op_t;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_C1, S_C2, S_C3, S_C4} state_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] lit_q, lit_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic [8:0]       ds_depth_q, ds_depth_d;
    logic [8:0]       rs_depth_q, rs_depth_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             ds_ne_q, ds_ne_d;    // DS held >= 1 element at acceptance
    logic             ds_two_q, ds_two_d;  // DS held >= 2 elements at acceptance

    logic             under, over, illegal, reject;
    logic [1:0]       rej_code;
    logic [1:0]       ds_mode_c, rs_mode_c;
    logic [WIDTH-1:0] ds_wdata, rs_wdata;
    logic             op_ready_c;

    // Limit checks on the opcode being offered, against current depths.
    always_comb begin
        under   = 1'b0;
        over    = 1'b0;
        illegal = 1'b0;
        case (op_t'(opcode))
            OP_LIT:               over  = (ds_depth_q == DS_CAP);
            OP_DROP:              under = (ds_depth_q == 9'd0);
            OP_DUP: begin
                under = (ds_depth_q == 9'd0);
                over  = (ds_depth_q == DS_CAP);
            end
            OP_SWAP:              under = (ds_depth_q < 9'd2);
            OP_OVER: begin
                under = (ds_depth_q < 9'd2);
                over  = (ds_depth_q == DS_CAP);
            end
            OP_TO_R: begin
                under = (ds_depth_q == 9'd0);
                over  = (rs_depth_q == RS_CAP);
            end
            OP_R_FROM, OP_R_FETCH: begin
                under = (rs_depth_q == 9'd0);
                over  = (ds_depth_q == DS_CAP);
            end
            OP_NOP, OP_CLEAR: ;
            default:              illegal = 1'b1;
        endcase
        reject   = under | over | illegal;
        rej_code = illegal ? 2'b11 : (under ? 2'b01 : 2'b10);
    end

    // Next-state, micro-step datapath updates and stack command decode.
    always_comb begin
        // NOTE: every _d starts from its _q (and every output from a default) so no path infers a latch.
        state_d    = state_q;
        op_d       = op_q;
        lit_d      = lit_q;
        tos_d      = tos_q;
        tmp_d      = tmp_q;
        ds_depth_d = ds_depth_q;
        rs_depth_d = rs_depth_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        ds_ne_d    = ds_ne_q;
        ds_two_d   = ds_two_q;
        ds_mode_c  = M_IDLE;
        rs_mode_c  = M_IDLE;
        ds_wdata   = tos_q;
        rs_wdata   = tos_q;
        op_ready_c = 1'b0;

        case (state_q)
            S_INIT: begin
                // NOTE: the stack memories have no reset of their own; this cycle empties them.
                ds_mode_c = M_CLR;
                rs_mode_c = M_CLR;
                state_d   = S_IDLE;
            end

            S_IDLE: begin
                op_ready_c = 1'b1;
                if (op_valid) begin
                    state_d  = S_C1;
                    lit_d    = lit_in;
                    ds_ne_d  = (ds_depth_q != 9'd0);
                    ds_two_d = (ds_depth_q >= 9'd2);
                    if (reject) begin
                        // A rejected op is consumed as a one-cycle no-op.
                        op_d = OP_NOP;
                        if (!error_q) begin
                            error_d    = 1'b1;
                            err_code_d = rej_code;
                        end
                    end else begin
                        op_d = op_t'(opcode);
                    end
                end
            end

            S_C1: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_LIT: begin
                        if (ds_ne_q) ds_mode_c = M_PUSH;
                        tos_d      = lit_q;
                        ds_depth_d = ds_depth_q + 9'd1;
                    end
                    OP_DUP: begin
                        ds_mode_c  = M_PUSH;
                        ds_depth_d = ds_depth_q + 9'd1;
                    end
                    OP_DROP: begin
                        if (ds_two_q) begin
                            ds_mode_c = M_POP;
                            state_d   = S_C2;
                        end else begin
                            ds_depth_d = ds_depth_q - 9'd1;
                        end
                    end
                    OP_SWAP, OP_OVER: begin
                        ds_mode_c = M_POP;
                        state_d   = S_C2;
                    end
                    OP_TO_R: begin
                        rs_mode_c = M_PUSH;
                        if (ds_two_q) begin
                            ds_mode_c = M_POP;
                            state_d   = S_C2;
                        end else begin
                            ds_depth_d = ds_depth_q - 9'd1;
                            rs_depth_d = rs_depth_q + 9'd1;
                        end
                    end
                    OP_R_FROM, OP_R_FETCH: begin
                        rs_mode_c = M_POP;
                        if (ds_ne_q) ds_mode_c = M_PUSH;
                        state_d = S_C2;
                    end
                    OP_CLEAR: begin
                        ds_mode_c  = M_CLR;
                        rs_mode_c  = M_CLR;
                        tos_d      = '0;
                        ds_depth_d = '0;
                        rs_depth_d = '0;
                        error_d    = 1'b0;
                        err_code_d = 2'b00;
                    end
                    default: ;
                endcase
            end

            S_C2: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_DROP: begin
                        tos_d      = ds_bus;
                        ds_depth_d = ds_depth_q - 9'd1;
                    end
                    OP_SWAP, OP_OVER: begin
                        tmp_d   = ds_bus;
                        state_d = S_C3;
                    end
                    OP_TO_R: begin
                        tos_d      = ds_bus;
                        ds_depth_d = ds_depth_q - 9'd1;
                        rs_depth_d = rs_depth_q + 9'd1;
                    end
                    OP_R_FROM: begin
                        tos_d      = rs_bus;
                        ds_depth_d = ds_depth_q + 9'd1;
                        rs_depth_d = rs_depth_q - 9'd1;
                    end
                    OP_R_FETCH: begin
                        tmp_d   = rs_bus;
                        tos_d   = rs_bus;
                        state_d = S_C3;
                    end
                    default: ;
                endcase
            end

            S_C3: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_SWAP: begin
                        ds_mode_c = M_PUSH;
                        tos_d     = tmp_q;
                    end
                    OP_OVER: begin
                        ds_mode_c = M_PUSH;
                        ds_wdata  = tmp_q;
                        state_d   = S_C4;
                    end
                    OP_R_FETCH: begin
                        rs_mode_c  = M_PUSH;
                        rs_wdata   = tmp_q;
                        ds_depth_d = ds_depth_q + 9'd1;
                    end
                    default: ;
                endcase
            end

            S_C4: begin
                // Only OVER reaches this step: push old TOS, copy NOS up.
                state_d    = S_IDLE;
                ds_mode_c  = M_PUSH;
                tos_d      = tmp_q;
                ds_depth_d = ds_depth_q + 9'd1;
            end

            default: state_d = S_INIT;
        endcase
    end

    // State and datapath registers; reset abandons any sequence in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_INIT;
            op_q       <= OP_NOP;
            lit_q      <= '0;
            tos_q      <= '0;
            tmp_q      <= '0;
            ds_depth_q <= '0;
            rs_depth_q <= '0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
            ds_ne_q    <= 1'b0;
            ds_two_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the same pre-edge values.
            state_q    <= state_d;
            op_q       <= op_d;
            lit_q      <= lit_d;
            tos_q      <= tos_d;
            tmp_q      <= tmp_d;
            ds_depth_q <= ds_depth_d;
            rs_depth_q <= rs_depth_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            ds_ne_q    <= ds_ne_d;
            ds_two_q   <= ds_two_d;
        end
    end

    // Commands read idle while reset is held; INIT's clear follows release.
    assign ds_mode  = reset_n ? ds_mode_c : M_IDLE;
    assign rs_mode  = reset_n ? rs_mode_c : M_IDLE;
    assign ds_bus   = (ds_mode == M_PUSH) ? ds_wdata : {WIDTH{1'bz}};
    assign rs_bus   = (rs_mode == M_PUSH) ? rs_wdata : {WIDTH{1'bz}};
    assign op_ready = op_ready_c;
    assign tos      = tos_q;
    assign ds_depth = ds_depth_q;
    assign rs_depth = rs_depth_q;
    assign error    = error_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: behavioural stack memories on both buses, an abstract
// FORTH stack model feeding a scoreboard, and directed op sequences.
module tb_stack_sequencer;

    localparam int MEM_DEPTH = 256;
    localparam int DS_CAP    = MEM_DEPTH + 1;
    localparam int RS_CAP    = MEM_DEPTH;

    localparam logic [3:0] NOP = 4'd0, LIT = 4'd1, DROP = 4'd2, DUP = 4'd3,
                           SWAP = 4'd4, OVER = 4'd5, TO_R = 4'd6,
                           R_FROM = 4'd7, R_FETCH = 4'd8, CLR = 4'd9;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] opcode;
    logic [7:0] lit_in;
    logic [7:0] tos;
    logic [8:0] ds_depth, rs_depth;
    logic [1:0] ds_mode, rs_mode;
    wire  [7:0] ds_bus, rs_bus;
    logic       error;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_fail   = 0;

    stack_sequencer #(.WIDTH(8), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .lit_in(lit_in), .tos(tos), .ds_depth(ds_depth),
        .rs_depth(rs_depth), .ds_mode(ds_mode), .ds_bus(ds_bus), .rs_mode(rs_mode),
        .rs_bus(rs_bus), .error(error), .err_code(err_code)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural stack memories ----------------
    logic [7:0] ds_mem [MEM_DEPTH];
    logic [7:0] rs_mem [MEM_DEPTH];
    int         ds_sp = 0, rs_sp = 0;
    int         ds_perr = 0, rs_perr = 0;
    logic       ds_drv_en, rs_drv_en;
    logic [7:0] ds_drv_val, rs_drv_val;

    assign ds_bus = ds_drv_en ? ds_drv_val : 8'bz;
    assign rs_bus = rs_drv_en ? rs_drv_val : 8'bz;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ds_drv_en <= 1'b0;
        end else begin
            ds_drv_en <= 1'b0;
            case (ds_mode)
                2'b00: ds_sp <= 0;
                2'b01: if (ds_sp < MEM_DEPTH) begin
                    ds_mem[ds_sp] <= ds_bus;
                    ds_sp         <= ds_sp + 1;
                end else ds_perr <= ds_perr + 1;
                2'b10: if (ds_sp > 0) begin
                    ds_drv_val <= ds_mem[ds_sp-1];
                    ds_drv_en  <= 1'b1;
                    ds_sp      <= ds_sp - 1;
                end else ds_perr <= ds_perr + 1;
                default: ;
            endcase
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rs_drv_en <= 1'b0;
        end else begin
            rs_drv_en <= 1'b0;
            case (rs_mode)
                2'b00: rs_sp <= 0;
                2'b01: if (rs_sp < MEM_DEPTH) begin
                    rs_mem[rs_sp] <= rs_bus;
                    rs_sp         <= rs_sp + 1;
                end else rs_perr <= rs_perr + 1;
                2'b10: if (rs_sp > 0) begin
                    rs_drv_val <= rs_mem[rs_sp-1];
                    rs_drv_en  <= 1'b1;
                    rs_sp      <= rs_sp - 1;
                end else rs_perr <= rs_perr + 1;
                default: ;
            endcase
        end
    end

    // ---------------- abstract model and scoreboard ----------------
    typedef struct {
        logic [7:0] tos;
        int         dsd, rsd;
        logic       err;
        logic [1:0] code;
        int         cycles;
        int         ds_sp, rs_sp;
        bit         has_nos, has_rtop;
        logic [7:0] ds_nos, rs_top;
    } exp_t;

    logic [7:0] m_ds[$];
    logic [7:0] m_rs[$];
    logic [7:0] m_tos;
    logic       m_err;
    logic [1:0] m_code;
    exp_t       sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ds.delete();
        m_rs.delete();
        m_tos  = 8'h00;
        m_err  = 1'b0;
        m_code = 2'b00;
        sb.delete();
    endfunction

    function automatic void model_apply(input logic [3:0] op, input logic [7:0] lit, output exp_t e);
        int d = m_ds.size();
        int r = m_rs.size();
        bit under = 0, over = 0, ill = 0;
        logic [7:0] t;
        case (op)
            LIT:             over  = (d == DS_CAP);
            DROP:            under = (d < 1);
            DUP:     begin under = (d < 1); over = (d == DS_CAP); end
            SWAP:            under = (d < 2);
            OVER:    begin under = (d < 2); over = (d == DS_CAP); end
            TO_R:    begin under = (d < 1); over = (r == RS_CAP); end
            R_FROM, R_FETCH: begin under = (r < 1); over = (d == DS_CAP); end
            NOP, CLR: ;
            default:         ill = 1;
        endcase
        e.cycles = 1;
        if (under || over || ill) begin
            if (!m_err) begin
                m_err  = 1'b1;
                m_code = ill ? 2'b11 : (under ? 2'b01 : 2'b10);
            end
        end else begin
            case (op)
                LIT:     m_ds.push_back(lit);
                DROP:    begin e.cycles = (d >= 2) ? 2 : 1; void'(m_ds.pop_back()); end
                DUP:     m_ds.push_back(m_ds[d-1]);
                SWAP:    begin t = m_ds[d-1]; m_ds[d-1] = m_ds[d-2]; m_ds[d-2] = t; e.cycles = 3; end
                OVER:    begin m_ds.push_back(m_ds[d-2]); e.cycles = 4; end
                TO_R:    begin e.cycles = (d >= 2) ? 2 : 1; m_rs.push_back(m_ds.pop_back()); end
                R_FROM:  begin e.cycles = 2; m_ds.push_back(m_rs.pop_back()); end
                R_FETCH: begin e.cycles = 3; m_ds.push_back(m_rs[r-1]); end
                CLR:     begin m_ds.delete(); m_rs.delete(); m_tos = 8'h00; m_err = 1'b0; m_code = 2'b00; end
                default: ;
            endcase
        end
        if (m_ds.size() > 0) m_tos = m_ds[m_ds.size()-1];
        e.tos      = m_tos;
        e.dsd      = m_ds.size();
        e.rsd      = m_rs.size();
        e.err      = m_err;
        e.code     = m_code;
        e.ds_sp    = (m_ds.size() > 0) ? m_ds.size() - 1 : 0;
        e.rs_sp    = m_rs.size();
        e.has_nos  = (m_ds.size() >= 2);
        e.ds_nos   = e.has_nos ? m_ds[m_ds.size()-2] : 8'h00;
        e.has_rtop = (m_rs.size() >= 1);
        e.rs_top   = e.has_rtop ? m_rs[m_rs.size()-1] : 8'h00;
    endfunction

    // Issue one op at a falling edge, wait for completion, score the result.
    // With poke set, op_valid is held high with another opcode while busy.
    task automatic do_op(input logic [3:0] op, input logic [7:0] lit, input bit poke = 0);
        exp_t e;
        int   busy = 0;
        int   waited = 0;
        while (op_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("ready_before_op", op_ready, 1);
        model_apply(op, lit, e);
        sb.push_back(e);
        op_valid = 1'b1;
        opcode   = op;
        lit_in   = lit;
        @(posedge clock);
        #1;
        op_valid = poke;
        opcode   = DUP;
        lit_in   = 8'hEE;
        while (busy < 10) begin
            @(negedge clock);
            if (op_ready === 1'b1) break;
            busy++;
        end
        op_valid = 1'b0;
        e = sb.pop_front();
        check($sformatf("op%0d.busy", op), busy, e.cycles);
        check($sformatf("op%0d.tos", op), tos, e.tos);
        check($sformatf("op%0d.ds_depth", op), ds_depth, e.dsd);
        check($sformatf("op%0d.rs_depth", op), rs_depth, e.rsd);
        check($sformatf("op%0d.error", op), error, e.err);
        check($sformatf("op%0d.err_code", op), err_code, e.code);
        check($sformatf("op%0d.ds_mem_cnt", op), ds_sp, e.ds_sp);
        check($sformatf("op%0d.rs_mem_cnt", op), rs_sp, e.rs_sp);
        if (e.has_nos)
            check($sformatf("op%0d.ds_nos", op), ds_mem[(ds_sp > 0) ? ds_sp - 1 : 0], e.ds_nos);
        if (e.has_rtop)
            check($sformatf("op%0d.rs_top", op), rs_mem[(rs_sp > 0) ? rs_sp - 1 : 0], e.rs_top);
        check($sformatf("op%0d.mem_protocol", op), ds_perr + rs_perr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        op_valid = 1'b0;
        opcode   = 4'd0;
        lit_in   = 8'h00;
        model_reset();

        // Reset state and the INIT clear cycle.
        #1;
        check("rst.tos", tos, 0);
        check("rst.ds_depth", ds_depth, 0);
        check("rst.rs_depth", rs_depth, 0);
        check("rst.error", error, 0);
        check("rst.err_code", err_code, 0);
        check("rst.op_ready", op_ready, 0);
        check("rst.ds_mode", ds_mode, 2'b11);
        check("rst.rs_mode", rs_mode, 2'b11);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("init.ds_mode", ds_mode, 2'b00);
        check("init.rs_mode", rs_mode, 2'b00);
        check("init.op_ready", op_ready, 0);
        @(negedge clock);
        check("idle.op_ready", op_ready, 1);
        check("idle.ds_mode", ds_mode, 2'b11);
        check("idle.rs_mode", rs_mode, 2'b11);
        check("idle.error", error, 0);

        // LIT/LIT/SWAP/DROP, with op_valid held during SWAP's busy window.
        do_op(LIT, 8'h11);
        do_op(LIT, 8'h22);
        do_op(SWAP, 8'h00, 1'b1);
        check("swap.tos", tos, 8'h11);
        do_op(DROP, 8'h00);
        check("drop.tos", tos, 8'h22);
        do_op(NOP, 8'h00);
        do_op(CLR, 8'h00);

        // Return-stack round trip from a single-element data stack.
        do_op(LIT, 8'h05);
        do_op(TO_R, 8'h00);
        do_op(R_FETCH, 8'h00);
        do_op(R_FROM, 8'h00);
        check("rs_trip.nos", ds_mem[0], 8'h05);
        do_op(CLR, 8'h00);

        // TO_R with a DS memory pop, then R_FETCH onto a non-empty DS.
        do_op(LIT, 8'h01);
        do_op(LIT, 8'h02);
        do_op(TO_R, 8'h00);
        do_op(R_FETCH, 8'h00);
        do_op(DUP, 8'h00);
        do_op(CLR, 8'h00);

        // OVER followed by two DROPs.
        do_op(LIT, 8'hA0);
        do_op(LIT, 8'hB0);
        do_op(OVER, 8'h00);
        check("over.tos", tos, 8'hA0);
        do_op(DROP, 8'h00);
        do_op(DROP, 8'h00);
        check("over_drop.tos", tos, 8'hA0);
        do_op(CLR, 8'h00);

        // Underflow, fill to capacity, overflow with first-error-wins, CLEAR.
        do_op(DROP, 8'h00);
        check("uflow.err_code", err_code, 2'b01);
        for (int i = 0; i < DS_CAP; i++) do_op(LIT, 8'(i + 3));
        check("full.ds_depth", ds_depth, 9'd257);
        do_op(LIT, 8'h77);
        do_op(DUP, 8'h00);
        check("oflow.err_code", err_code, 2'b01);
        do_op(CLR, 8'h00);

        // Illegal opcode, then a later underflow must not replace its code.
        do_op(4'hC, 8'h00);
        do_op(R_FROM, 8'h00);
        do_op(SWAP, 8'h00);
        do_op(CLR, 8'h00);

        // Reset asserted during OVER's capture cycle.
        do_op(LIT, 8'h01);
        do_op(LIT, 8'hA0);
        do_op(LIT, 8'hB0);
        op_valid = 1'b1;
        opcode   = OVER;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.tos", tos, 0);
        check("midrst.ds_depth", ds_depth, 0);
        check("midrst.rs_depth", rs_depth, 0);
        check("midrst.op_ready", op_ready, 0);
        check("midrst.ds_mode", ds_mode, 2'b11);
        check("midrst.rs_mode", rs_mode, 2'b11);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("midrst.init_ds_mode", ds_mode, 2'b00);
        check("midrst.init_rs_mode", rs_mode, 2'b00);
        @(negedge clock);
        check("midrst.op_ready", op_ready, 1);
        do_op(LIT, 8'h33);
        check("midrst.lit_tos", tos, 8'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
